// File: rtl/subckt_bist_sequencer.sv
// BIST sequencer: resets one subcircuit, streams LFSR patterns, flushes its pipeline and folds responses into a MISR.
// Optional golden-signature comparison is enabled by defining BIST_GOLDEN_CMP_EN.
module subckt_bist_sequencer #(
  parameter int               N_IN      = 4,
  parameter int               LAT       = 5,
  parameter int               N_PAT     = 64,
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] MISR_POLY = 16'h1021,
  parameter logic [15:0]      LFSR_SEED = 16'hACE1
) (
  input  logic             I1294_clk,
  input  logic             I1301_rst,
  input  logic             start,
  input  logic             sut_out,
`ifdef BIST_GOLDEN_CMP_EN
  input  logic [SIG_W-1:0] golden,
`endif
  output logic [N_IN-1:0]  sut_in,
  output logic             sut_rst_n,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             pass
);

  typedef enum logic [2:0] {IDLE, SUTRST, APPLY, FLUSH, DONE} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      pat_cnt;
  logic [3:0]       flush_cnt;
  logic             rst_cnt;
  logic             apply_q;
  logic [LAT-1:0]   vld;
  logic [SIG_W-1:0] misr_next;
  logic [SIG_W-1:0] sig_final;
  logic             start_ok;

  always_comb begin
    misr_next = {signature[SIG_W-2:0], 1'b0}
              ^ (signature[SIG_W-1] ? MISR_POLY : '0)
              ^ {{(SIG_W-1){1'b0}}, sut_out};
    // The last capture lands on the same edge that raises done.
    sig_final = vld[LAT-1] ? misr_next : signature;
    start_ok  = start && ((state == IDLE) || (state == DONE));
  end

  // Outputs are registered from the state, so they trail the state register by one cycle.
  always_ff @(posedge I1294_clk or negedge I1301_rst) begin
    if (!I1301_rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      pat_cnt   <= '0;
      flush_cnt <= '0;
      rst_cnt   <= 1'b0;
      apply_q   <= 1'b0;
      vld       <= '0;
      sut_in    <= '0;
      sut_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= '0;
`ifdef BIST_GOLDEN_CMP_EN
      pass      <= 1'b0;
`endif
    end else begin
      vld       <= vld << 1;
      vld[0]    <= apply_q;
      if (vld[LAT-1]) signature <= misr_next;
      apply_q   <= (state == APPLY);
      sut_in    <= (state == APPLY) ? lfsr[N_IN-1:0] : '0;
      sut_rst_n <= (state != SUTRST);
      busy      <= (state == SUTRST) || (state == APPLY) || (state == FLUSH);

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state     <= SUTRST;
            lfsr      <= LFSR_SEED;
            pat_cnt   <= '0;
            flush_cnt <= '0;
            rst_cnt   <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
`ifdef BIST_GOLDEN_CMP_EN
            pass      <= 1'b0;
`endif
          end else if (state == DONE) begin
            done <= 1'b1;
`ifdef BIST_GOLDEN_CMP_EN
            if (!done) pass <= (sig_final == golden);
`endif
          end
        end
        SUTRST: begin
          if (rst_cnt) state <= APPLY;
          else         rst_cnt <= 1'b1;
        end
        APPLY: begin
          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          if (pat_cnt == 16'(N_PAT - 1)) state <= FLUSH;
          else                           pat_cnt <= pat_cnt + 16'd1;
        end
        FLUSH: begin
          if (flush_cnt == 4'(LAT - 1)) state <= DONE;
          else                          flush_cnt <= flush_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BIST_GOLDEN_CMP_EN
  assign pass = 1'b0;
`endif

endmodule
